// File: rtl/fifo_unpacker.sv
// fifo_unpacker: drains a show-ahead FIFO and splits each IW word into OW sub-words.
// Optional macro FIFO_UNPACK_MSB_FIRST_EN selects MSB-first sub-word order.
module fifo_unpacker #(
  parameter int IW = 32,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [IW-1:0] fifo_dat,
  output logic          fifo_rd,
  output logic [OW-1:0] out_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          out_last,
  output logic          busy
);

  localparam int RATIO = IW / OW;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] IDX_END = CW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] idx_inc;
  logic [IW-1:0] sr_q, sr_d;
  logic [IW-1:0] sr_nx;
  logic [OW-1:0] dat_q, dat_d;
  logic          last_q, last_d;
  logic [OW-1:0] first_sw;
  logic [OW-1:0] next_sw;
  logic          acc;
  logic          at_end;
  logic          ld;

  assign idx_inc = idx_q + CW'(1);
  assign at_end  = (idx_q == IDX_END);
  assign acc     = clk_en & (state_q == EMIT) & out_rdy;

  // Pop is held off during reset so a non-empty FIFO is not drained.
  assign ld = ~rst & clk_en & en & ~fifo_empty &
              ((state_q == IDLE) | (acc & at_end));

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign sr_nx    = sr_q << OW;
  assign first_sw = fifo_dat[IW-1 -: OW];
  assign next_sw  = sr_nx[IW-1 -: OW];
`else
  assign sr_nx    = sr_q >> OW;
  assign first_sw = fifo_dat[OW-1:0];
  assign next_sw  = sr_nx[OW-1:0];
`endif

  // Next-state: flush, load a word, or step to the next sub-word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    dat_d   = dat_q;
    last_d  = last_q;
    if (clk_en) begin
      if (!en) begin
        state_d = IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end else if (ld) begin
        state_d = EMIT;
        sr_d    = fifo_dat;
        dat_d   = first_sw;
        idx_d   = '0;
        last_d  = 1'b0;
      end else if (acc) begin
        if (!at_end) begin
          idx_d  = idx_inc;
          sr_d   = sr_nx;
          dat_d  = next_sw;
          last_d = (idx_inc == IDX_END);
        end else begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      dat_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
    end
  end

  assign fifo_rd  = ld;
  assign out_dat  = dat_q;
  assign out_vld  = (state_q == EMIT);
  assign out_last = last_q;
  assign busy     = out_vld;

endmodule
